// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of the shared combinational calculator ALU.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: ties always go to requester 0 (default: round robin).
module alu_share_arbiter #(
    parameter int WIDTH  = 9,
    parameter int SETTLE = 1
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             req0,
    input  logic [2:0]       opcode0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [2:0]       opcode1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       cur_id;
    logic       win;
    logic       any_req;

    assign any_req = req0 | req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win = ~req0;
`else
    logic last_id;
    // On a tie the requester that did not win last time goes next.
    assign win = (req0 & req1) ? ~last_id : req1;

    always_ff @(posedge hwclk) begin
        if (reset)
            last_id <= 1'b1;
        else if (state == IDLE && any_req)
            last_id <= win;
    end
`endif

    always_ff @(posedge hwclk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = EXEC;
            EXEC:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ALU drive regs only load on a grant, so the ALU sees stable inputs for the whole EXEC.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_opcode <= '0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            cur_id     <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        alu_op1    <= win ? a1 : a0;
                        alu_op2    <= win ? b1 : b0;
                        alu_opcode <= win ? opcode1 : opcode0;
                        cur_id     <= win;
                        cnt        <= CNT_INIT;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_id     <= cur_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack0 = (state == RESP) && !cur_id;
    assign ack1 = (state == RESP) &&  cur_id;
    assign busy = (state != IDLE);

endmodule
